// File: rtl/csa_resolver_pkg.sv
// ---------------------------------------------------------------------------
// csa_pkg
// Shared definitions for the sequential carry-propagate resolver that sits
// after the 5:3 counter compressor tree.
//   state_t          : controller states (IDLE / BUSY / DONE)
//   DEF_WIDTH        : default width of each redundant input vector
//   DEF_DIGIT        : default number of bits resolved per clock
//   ndig()           : number of digit slices (cycles) per operation
//   clog2()          : counter width for the digit index, never below one bit
// ---------------------------------------------------------------------------
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DIGIT = 8;

    // Number of DIGIT-bit slices needed to cover WIDTH bits.
    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // Bits needed to index NDIG digits. A single-digit configuration still
    // gets a one-bit counter so the declaration never collapses to zero width.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

    localparam int DEF_NDIG = ndig(DEF_WIDTH, DEF_DIGIT);

endpackage

// File: rtl/csa_resolver_if.sv
// ---------------------------------------------------------------------------
// csa_resolver_if
// Handshake bundle between the compressor tree, the resolver and the product
// register.
//   in_valid / in_ready   : operand-side handshake
//   s_vec / c_vec         : redundant sum and aligned carry vectors
//   out_valid / out_ready : result-side handshake
//   result                : WIDTH+1 bit binary sum, MSB is the final carry
// Modports:
//   slave  : the resolver itself
//   master : the surrounding environment (compressor tree + product register)
// ---------------------------------------------------------------------------
interface csa_resolver_if
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] s_vec;
    logic [WIDTH-1:0] c_vec;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;

    modport slave (
        input  in_valid,
        input  s_vec,
        input  c_vec,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result
    );

    modport master (
        output in_valid,
        output s_vec,
        output c_vec,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result
    );

endinterface

// File: rtl/csa_resolver_adder.sv
// ---------------------------------------------------------------------------
// csa_digit_adder
// DIGIT-bit ripple-carry adder used once per clock by the resolver. Keeping
// the slice narrow bounds the critical path to one digit add plus carry-in.
//   a, b : digit operands
//   cin  : carry from the previous digit
//   sum  : digit sum
//   cout : carry into the next digit
// ---------------------------------------------------------------------------
module csa_digit_adder #(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] carry;

    // Explicit bit-by-bit ripple: each full adder feeds its carry to the next
    // position, and the top carry leaves as cout.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[DIGIT];
    end

endmodule

// File: rtl/csa_resolver.sv
// ---------------------------------------------------------------------------
// csa_resolver
// Sequential carry-propagate stage. Accepts one (sum, carry) vector pair and
// resolves it into a binary WIDTH+1 bit result, DIGIT bits per clock, so the
// full-width add never needs a wide ripple or prefix adder.
// Ports:
//   clk   : single clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : csa_resolver_if slave modport (operand and result handshakes)
// Timing: acceptance at edge T0, digit k resolved at edge T(k+1), out_valid
// rises after edge T(NDIG). With out_ready held high a new pair is taken on
// the same edge the previous result is consumed (one result per NDIG+1).
// ---------------------------------------------------------------------------
module csa_resolver
    import csa_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DIGIT = DEF_DIGIT
) (
    input  logic            clk,
    input  logic            rst_n,
    csa_resolver_if.slave   bus
);

    localparam int NDIG  = ndig(WIDTH, DIGIT);
    localparam int CNT_W = clog2(NDIG);

    // The digit slicing only makes sense when WIDTH is a whole number of
    // digits; anything else is rejected while elaborating.
    generate
        if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_params
            $error("csa_resolver: WIDTH (%0d) must be a non-zero multiple of DIGIT (%0d)",
                   WIDTH, DIGIT);
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] s_sh;
    logic [WIDTH-1:0] c_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             out_valid_q;
    logic [WIDTH:0]   result_q;

    logic [DIGIT-1:0] digit_sum;
    logic             digit_cout;
    logic             last_digit;

    // The single digit adder always works on the low slice of the shift
    // registers together with the running carry.
    csa_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .a    (s_sh[DIGIT-1:0]),
        .b    (c_sh[DIGIT-1:0]),
        .cin  (carry),
        .sum  (digit_sum),
        .cout (digit_cout)
    );

    assign last_digit = (cnt == CNT_W'(NDIG - 1));

    // in_ready is only combinational on out_ready in DONE, where the result
    // handoff and the next acceptance share one edge.
    assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

    // Controller and datapath in one block. IDLE waits for a pair, BUSY adds
    // one digit per cycle into its slice of the result, DONE holds the result
    // until the product register takes it and optionally chains the next pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            s_sh        <= '0;
            c_sh        <= '0;
            carry       <= 1'b0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        s_sh  <= bus.s_vec;
                        c_sh  <= bus.c_vec;
                        carry <= 1'b0;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    for (int k = 0; k < NDIG; k++) begin
                        if (cnt == CNT_W'(k)) begin
                            result_q[k*DIGIT +: DIGIT] <= digit_sum;
                        end
                    end
                    carry <= digit_cout;
                    s_sh  <= s_sh >> DIGIT;
                    c_sh  <= c_sh >> DIGIT;
                    cnt   <= cnt + 1'b1;
                    if (last_digit) begin
                        result_q[WIDTH] <= digit_cout;
                        out_valid_q     <= 1'b1;
                        state           <= DONE;
                    end
                end

                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            s_sh  <= bus.s_vec;
                            c_sh  <= bus.c_vec;
                            carry <= 1'b0;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    out_valid_q <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/csa_resolver.md
# csa_resolver

Sequential carry-propagate stage at the output of the 5:3 counter compressor tree. It accepts one redundant (sum vector, carry vector) pair and resolves it into a single binary result. It adds one DIGIT-bit slice per clock, so a wide result is produced without a full-width ripple or prefix adder. It sits between the multiplier's compressor array and the product register, with valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, bit width of each redundant input vector; must be a multiple of DIGIT and ≥ DIGIT
- DIGIT, 8, bits resolved per clock; NDIG = WIDTH/DIGIT cycles per operation
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion sampled synchronously to clk
- in_valid  input  1  s_vec/c_vec valid
- in_ready  output  1  block can accept an operand pair this cycle
- s_vec  input  WIDTH  sum vector from compressor tree
- c_vec  input  WIDTH  carry vector, already aligned (bit i has weight 2^i)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- result  output  WIDTH+1  s_vec + c_vec, unsigned, MSB is final carry

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, capture s_vec and c_vec into shift registers, clear carry flop, clear digit counter, go to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle add the low DIGIT bits of s, c and the carry flop. Write the DIGIT-bit sum into result slice [cnt*DIGIT +: DIGIT], update the carry flop, shift s and c right by DIGIT, and increment cnt. When cnt == NDIG-1, write result[WIDTH] = final carry-out and go to DONE.
- DONE: out_valid=1, result stable. in_ready = out_ready. On out_valid&out_ready: if in_valid is also high, capture the new pair and go to BUSY (back-to-back); else go to IDLE.
- Arithmetic is unsigned modulo 2^(WIDTH+1). No overflow is possible; the carry-out lands in result[WIDTH].
- in_valid and operand values are ignored outside IDLE and the DONE handoff cycle. Upstream must hold the pair stable until accepted.
- Reset values: state=IDLE, in_ready=1 (after reset deassertion), out_valid=0, result=0, carry=0, cnt=0.
- Reset asserted mid-operation (BUSY or DONE): the operation is abandoned with no output handshake. All outputs return to their reset values asynchronously.

## Timing
- Accept at rising edge T0. Digit k is resolved at edge T(k+1). out_valid rises after edge T(NDIG): latency is NDIG cycles from acceptance to valid (4 for defaults).
- out_valid and result hold indefinitely under out_ready=0 (backpressure). result must not change while out_valid=1.
- Throughput with out_ready tied high: one result per NDIG+1 cycles. The handoff in DONE accepts the next pair on the same edge the result is consumed.
- The critical path is one DIGIT-bit add plus carry-in. No combinational path runs from in_valid to out_valid. in_ready depends combinationally on out_ready only in DONE.

## Structure
- Shared package csa_pkg holds:
  - the state enum (IDLE/BUSY/DONE)
  - default WIDTH/DIGIT localparams
  - the NDIG derivation and the counter width function clog2(NDIG)
- One sub-module, csa_digit_adder (DIGIT-bit ripple adder: a, b, cin → sum, cout), is instantiated once and used every cycle.
- Elaboration-time check: WIDTH % DIGIT == 0.

## Test plan
- Basic: s_vec=0x0000_0005, c_vec=0x0000_0003 accepted at T0 → out_valid at T4, result=0x0_0000_0008.
- Full carry ripple across all digits: s_vec=0xFFFF_FFFF, c_vec=0x0000_0001 → result=0x1_0000_0000. Max case s_vec=c_vec=0xFFFF_FFFF → result=0x1_FFFF_FFFE.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. result and out_valid stay stable, in_ready=0. Release → one handshake, then IDLE.
- Back-to-back with in_valid and out_ready always high, pairs (1,2), (3,4), (0x8000_0000, 0x8000_0000) → results 3, 7, 0x1_0000_0000 exactly NDIG+1 cycles apart, no drops or duplicates.
- Reset mid-BUSY: assert rst_n=0 at cycle 2 of an operation → out_valid=0 and result=0 immediately. After release in_ready=1 and no stale result ever appears.
- Random: 10k random pairs with random out_ready/in_valid gaps → every result equals s_vec+c_vec (WIDTH+1 bits), checked against a reference model, results in order.
